// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding, defaults and byte-lane constants for the instruction loader
package imem_loader_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int LEN_W_DEF = 16;
  localparam int LANE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [1:0] LAST_LANE = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_BYTES,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four bytes into a little-endian word, first byte in the LSB lane
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_nxt_o,
  output logic              full_o
);
  logic [1:0]        idx_q;
  logic [WORD_W-1:0] word_q;
  // word_nxt_o already includes the byte being pushed, so the fourth byte can be captured on its own edge
  always_comb begin
    word_nxt_o = word_q;
    word_nxt_o[LANE_W*idx_q +: LANE_W] = byte_i;
  end
  assign full_o = push_i && idx_q == LAST_LANE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (push_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word_nxt_o;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte image and writes it into instruction memory,
// holding the core in reset until the image has been loaded without error
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             core_rst_n_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_loaded_o
);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  state_t            state_q;
  logic [LEN_W-1:0]  len_q, word_idx_q;
  logic              in_ready_q, mem_we_q, core_rst_n_q, busy_q, done_q, err_q;
  logic [31:0]       mem_addr_q, mem_wdata_q;
  logic              xfer, full;
  logic [15:0]       hdr;
  logic [WORD_W-1:0] word_nxt;
  assign xfer = in_valid_i && in_ready_q;
  assign hdr  = {in_data_i, len_q[7:0]};
  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == S_LEN_HI),
    .push_i     (xfer && state_q == S_BYTES),
    .byte_i     (in_data_i),
    .word_nxt_o (word_nxt),
    .full_o     (full)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          state_q      <= S_LEN_LO;
          len_q        <= '0;
          word_idx_q   <= '0;
          in_ready_q   <= 1'b1;
          core_rst_n_q <= 1'b0;
          busy_q       <= 1'b1;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
        S_LEN_LO: if (xfer) begin
          len_q   <= LEN_W'(in_data_i);
          state_q <= S_LEN_HI;
        end
        S_LEN_HI: if (xfer) begin
          len_q      <= LEN_W'(hdr);
          in_ready_q <= hdr != 16'd0 && int'(hdr) <= DEPTH;
          if (hdr == 16'd0) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else if (int'(hdr) > DEPTH) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_BYTES;
          end
        end
        S_BYTES: if (full) begin
          state_q     <= S_WRITE;
          in_ready_q  <= 1'b0;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= {{(30-LEN_W){1'b0}}, word_idx_q, 2'b00};
          mem_wdata_q <= word_nxt;
        end
        S_WRITE: begin
          word_idx_q <= word_idx_q + ONE;
          if (word_idx_q + ONE == len_q) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else begin
            state_q    <= S_BYTES;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign in_ready_o     = in_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign core_rst_n_o   = core_rst_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = word_idx_q;
endmodule
